// File: rtl/wait_buffer_issue_pkg.sv
// Shared dispatcher types: the wait-buffer entry and its tag/register index fields.
// Both the wait buffer and its issue stage use these types.
package wait_buffer_issue_pkg;

  localparam int NUM_TAGS          = 8;
  localparam int TAG_WIDTH         = $clog2(NUM_TAGS);
  localparam int PC_WIDTH          = 32;
  localparam int WARP_WIDTH        = 32;
  localparam int REG_IDX_WIDTH     = 6;
  localparam int OPERANDS_PER_INST = 2;

  typedef logic [TAG_WIDTH-1:0]     tag_t;
  typedef logic [REG_IDX_WIDTH-1:0] reg_idx_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]                pc;
    logic [WARP_WIDTH-1:0]              act_mask;
    tag_t                               tag;
    reg_idx_t                           dst_reg;
    logic [OPERANDS_PER_INST-1:0]       operands_ready;
    tag_t     [OPERANDS_PER_INST-1:0]   operand_tags;
    reg_idx_t [OPERANDS_PER_INST-1:0]   operands;
  } entry_t;

endpackage

// File: rtl/age_matrix_arbiter.sv
// Oldest-first arbiter: an NxN older-than matrix updated on insert, one-hot grant.
module age_matrix_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] insert_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] grant_o
);

  // older_q[i][j] set means entry i was inserted before entry j
  logic [N-1:0][N-1:0] older_q;
  logic [N-1:0]        blocked;
  logic [N-1:0]        cand;
  logic                found;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      older_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (insert_i[i])      older_q[i][j] <= 1'b0;
          else if (insert_i[j]) older_q[i][j] <= 1'b1;
        end
      end
    end
  end

  // Lowest-index fallback keeps the grant one-hot even for never-ordered entries
  always_comb begin
    blocked = '0;
    cand    = '0;
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (req_i[j] && older_q[j][i]) blocked[i] = 1'b1;
      end
      cand[i] = req_i[i] && !blocked[i];
    end
    for (int i = 0; i < N; i++) begin
      if (cand[i] && !found) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wait_buffer_issue.sv
// Issue stage of the wait buffer: tracks operand wakeups, picks the oldest ready
// entry and hands it to the operand collector through a one-deep output register.
module wait_buffer_issue
  import wait_buffer_issue_pkg::*;
#(
  parameter int NumTags               = 8,
  parameter int PcWidth               = 32,
  parameter int WarpWidth             = 32,
  parameter int WaitBufferSizePerWarp = 4,
  parameter int RegIdxWidth           = 6,
  parameter int OperandsPerInst       = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic   [WaitBufferSizePerWarp-1:0]           wb_valid_i,
  input  entry_t [WaitBufferSizePerWarp-1:0]           wb_entries_i,
  input  logic   [WaitBufferSizePerWarp-1:0]           wb_insert_i,
  input  logic                                         eu_valid_i,
  input  logic   [$clog2(NumTags)-1:0]                 eu_tag_i,
  output logic   [WaitBufferSizePerWarp-1:0]           wb_release_o,
  output logic                                         credit_give_o,
  output logic                                         opc_valid_o,
  input  logic                                         opc_ready_i,
  output logic   [PcWidth-1:0]                         opc_pc_o,
  output logic   [WarpWidth-1:0]                       opc_act_mask_o,
  output logic   [$clog2(NumTags)-1:0]                 opc_tag_o,
  output logic   [RegIdxWidth-1:0]                     opc_dst_reg_o,
  output logic   [OperandsPerInst-1:0][RegIdxWidth-1:0] opc_operands_o
);

  localparam int N = WaitBufferSizePerWarp;
  localparam int M = OperandsPerInst;

  logic [N-1:0][M-1:0] woken_q;
  logic [N-1:0][M-1:0] woken_d;
  logic [N-1:0][M-1:0] wb_hit;
  logic [N-1:0]        eligible;
  logic [N-1:0]        grant;
  logic                load;
  logic                valid_q;
  entry_t              sel_entry;
  entry_t              payload_q;

  always_comb begin
    wb_hit = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < M; k++) begin
        wb_hit[i][k] = eu_valid_i && (eu_tag_i == wb_entries_i[i].operand_tags[k]);
      end
    end
  end

  // A fresh insert starts from the writeback seen in its own cycle only
  always_comb begin
    woken_d = woken_q;
    for (int i = 0; i < N; i++) begin
      if (wb_insert_i[i])       woken_d[i] = wb_hit[i];
      else if (wb_release_o[i]) woken_d[i] = '0;
      else if (wb_valid_i[i])   woken_d[i] = woken_q[i] | wb_hit[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) woken_q <= '0;
    else         woken_q <= woken_d;
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = wb_valid_i[i] && (&(wb_entries_i[i].operands_ready | woken_q[i]));
    end
  end

  age_matrix_arbiter #(
    .N (N)
  ) u_age_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .insert_i (wb_insert_i),
    .req_i    (eligible),
    .grant_o  (grant)
  );

  assign load          = rst_ni && (|eligible) && (!valid_q || opc_ready_i);
  assign wb_release_o  = load ? grant : '0;
  assign credit_give_o = load;

  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_entry = wb_entries_i[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else if (load) begin
      valid_q   <= 1'b1;
      payload_q <= sel_entry;
    end else if (opc_ready_i) begin
      valid_q   <= 1'b0;
    end
  end

  assign opc_valid_o    = valid_q;
  assign opc_pc_o       = payload_q.pc;
  assign opc_act_mask_o = payload_q.act_mask;
  assign opc_tag_o      = payload_q.tag;
  assign opc_dst_reg_o  = payload_q.dst_reg;
  assign opc_operands_o = payload_q.operands;

  a_no_insert_on_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (wb_insert_i & wb_valid_i) == '0)
    else $error("wait_buffer_issue: insert on an already valid entry");

  a_single_insert: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(wb_insert_i))
    else $error("wait_buffer_issue: more than one insert in a cycle");

endmodule

// File: tb/tb_wait_buffer_issue.sv
// Directed bench for wait_buffer_issue: stimulus pushes expected issues into a
// queue that a monitor pops whenever the operand collector accepts one.
module tb_wait_buffer_issue;
  import wait_buffer_issue_pkg::*;

  localparam int N = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic   [N-1:0]       wb_valid_i;
  entry_t [N-1:0]       wb_entries_i;
  logic   [N-1:0]       wb_insert_i;
  logic                 eu_valid_i;
  tag_t                 eu_tag_i;
  logic   [N-1:0]       wb_release_o;
  logic                 credit_give_o;
  logic                 opc_valid_o;
  logic                 opc_ready_i;
  logic   [31:0]        opc_pc_o;
  logic   [31:0]        opc_act_mask_o;
  tag_t                 opc_tag_o;
  reg_idx_t             opc_dst_reg_o;
  logic   [1:0][5:0]    opc_operands_o;

  int       n_checks   = 0;
  int       n_fail     = 0;
  int       credit_cnt = 0;
  entry_t   exp_q[$];
  logic [N-1:0] last_rel;

  always #5 clk_i = ~clk_i;

  wait_buffer_issue #(
    .NumTags(8), .PcWidth(32), .WarpWidth(32),
    .WaitBufferSizePerWarp(N), .RegIdxWidth(6), .OperandsPerInst(2)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wb_valid_i     (wb_valid_i),
    .wb_entries_i   (wb_entries_i),
    .wb_insert_i    (wb_insert_i),
    .eu_valid_i     (eu_valid_i),
    .eu_tag_i       (eu_tag_i),
    .wb_release_o   (wb_release_o),
    .credit_give_o  (credit_give_o),
    .opc_valid_o    (opc_valid_o),
    .opc_ready_i    (opc_ready_i),
    .opc_pc_o       (opc_pc_o),
    .opc_act_mask_o (opc_act_mask_o),
    .opc_tag_o      (opc_tag_o),
    .opc_dst_reg_o  (opc_dst_reg_o),
    .opc_operands_o (opc_operands_o)
  );

  function automatic entry_t mk_entry(logic [31:0] pc, logic [1:0] rdy, tag_t t1);
    entry_t e;
    e.pc              = pc;
    e.act_mask        = ~pc;
    e.tag             = pc[6:4];
    e.dst_reg         = pc[9:4];
    e.operands_ready  = rdy;
    e.operand_tags[0] = 3'd0;
    e.operand_tags[1] = t1;
    e.operands[0]     = {2'b00, pc[7:4]};
    e.operands[1]     = 6'd33;
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic monitor();
    entry_t e;
    forever begin
      @(negedge clk_i);
      if (credit_give_o) credit_cnt++;
      if (rst_ni && opc_valid_o && opc_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_issue: got pc %0h expected no issue", opc_pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("issue_pc", {32'h0, opc_pc_o}, {32'h0, e.pc});
          chk("issue_payload", {11'h0, opc_act_mask_o, opc_tag_o, opc_dst_reg_o, opc_operands_o},
              {11'h0, e.act_mask, e.tag, e.dst_reg, e.operands});
        end
      end
    end
  endtask

  // Wait-buffer model: a released entry drops its valid on the following cycle
  task automatic tick();
    logic [N-1:0] r;
    @(negedge clk_i);
    r        = wb_release_o;
    last_rel = r;
    @(posedge clk_i);
    #1;
    wb_valid_i  = wb_valid_i & ~r;
    wb_insert_i = '0;
    eu_valid_i  = 1'b0;
  endtask

  task automatic ins(int i, entry_t e);
    wb_entries_i[i] = e;
    wb_insert_i[i]  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    entry_t e;
    fork
      monitor();
    join_none

    rst_ni       = 1'b0;
    wb_valid_i   = '0;
    wb_insert_i  = '0;
    wb_entries_i = '0;
    eu_valid_i   = 1'b0;
    eu_tag_i     = '0;
    opc_ready_i  = 1'b1;

    // Entry 0 fully ready while reset is held, issues right after reset exit
    e = mk_entry(32'h100, 2'b11, 3'd0);
    wb_entries_i[0] = e;
    wb_valid_i      = 4'b0001;
    repeat (3) tick();
    chk("reset_valid", opc_valid_o, 0);
    chk("reset_release", last_rel, 0);
    chk("reset_pc", opc_pc_o, 0);
    chk("reset_credit", credit_cnt, 0);
    exp_q.push_back(e);
    rst_ni = 1'b1;
    tick();
    chk("s1_release", last_rel, 4'b0001);
    chk("s1_valid", opc_valid_o, 1);
    tick();
    chk("s1_drain", opc_valid_o, 0);

    // Two entries waiting on tag 3: older first, younger one cycle later
    ins(0, mk_entry(32'h200, 2'b01, 3'd3));
    tick();
    wb_valid_i[0] = 1'b1;
    ins(1, mk_entry(32'h210, 2'b01, 3'd3));
    tick();
    chk("s2_not_ready", last_rel, 0);
    wb_valid_i[1] = 1'b1;
    tick();
    chk("s2_waiting", last_rel, 0);
    exp_q.push_back(mk_entry(32'h200, 2'b01, 3'd3));
    exp_q.push_back(mk_entry(32'h210, 2'b01, 3'd3));
    eu_valid_i = 1'b1;
    eu_tag_i   = 3'd3;
    tick();
    chk("s2_same_cycle_wb", last_rel, 0);
    tick();
    chk("s2_older_first", last_rel, 4'b0001);
    tick();
    chk("s2_younger_next", last_rel, 4'b0010);
    tick();
    tick();
    chk("s2_drain", opc_valid_o, 0);

    // Stall with a full register and three entries waiting behind it
    opc_ready_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i > 0) wb_valid_i[i-1] = 1'b1;
      ins(i, mk_entry(32'h300 + 32'(16 * i), 2'b11, 3'd0));
      tick();
    end
    wb_valid_i[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s3_stall_pc", opc_pc_o, 32'h300);
      chk("s3_stall_valid", opc_valid_o, 1);
      chk("s3_stall_release", last_rel, 0);
    end
    for (int i = 0; i < N; i++) exp_q.push_back(mk_entry(32'h300 + 32'(16 * i), 2'b11, 3'd0));
    opc_ready_i = 1'b1;
    tick();
    chk("s3_issue1", last_rel, 4'b0010);
    tick();
    chk("s3_issue2", last_rel, 4'b0100);
    tick();
    chk("s3_issue3", last_rel, 4'b1000);
    tick();
    chk("s3_no_more", last_rel, 0);
    chk("s3_drain", opc_valid_o, 0);

    // Insert coinciding with the writeback of its missing operand
    ins(2, mk_entry(32'h400, 2'b01, 3'd5));
    eu_valid_i = 1'b1;
    eu_tag_i   = 3'd5;
    tick();
    chk("s4_insert_cycle", last_rel, 0);
    wb_valid_i[2] = 1'b1;
    exp_q.push_back(mk_entry(32'h400, 2'b01, 3'd5));
    tick();
    chk("s4_woken_issue", last_rel, 4'b0100);
    tick();
    tick();

    // Writeback to a non-valid entry leaves no wakeup behind
    wb_entries_i[3] = mk_entry(32'h450, 2'b01, 3'd4);
    eu_valid_i = 1'b1;
    eu_tag_i   = 3'd4;
    tick();
    wb_valid_i[3] = 1'b1;
    tick();
    chk("s5_no_wake", last_rel, 0);
    tick();
    chk("s5_no_wake2", last_rel, 0);
    chk("s5_no_issue", opc_valid_o, 0);
    wb_valid_i[3] = 1'b0;
    tick();

    // Reset during a stall drops the held instruction silently
    opc_ready_i = 1'b0;
    ins(0, mk_entry(32'h500, 2'b11, 3'd0));
    tick();
    wb_valid_i[0] = 1'b1;
    tick();
    chk("s6_load", last_rel, 4'b0001);
    tick();
    tick();
    chk("s6_held", opc_valid_o, 1);
    rst_ni     = 1'b0;
    wb_valid_i = '0;
    tick();
    chk("s6_reset_drop", opc_valid_o, 0);
    chk("s6_reset_release", last_rel, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("s6_after_reset", opc_valid_o, 0);
    chk("credit_total", credit_cnt, 9);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wait_buffer_issue.md
WAIT_BUFFER_ISSUE -- requirements
Module: wait_buffer_issue

Interface
REQ-001 SHALL have parameter NumTags, default 8, number of in-flight result tags.
REQ-002 SHALL have parameter PcWidth, default 32, program counter width.
REQ-003 SHALL have parameter WarpWidth, default 32, threads per warp (active-mask width).
REQ-004 SHALL have parameter WaitBufferSizePerWarp, default 4, wait-buffer entries N.
REQ-005 SHALL have parameter RegIdxWidth, default 6, register index width.
REQ-006 SHALL have parameter OperandsPerInst, default 2, operands per instruction M.
REQ-007 SHALL have one clock; reset is synchronous and active-low: clk_i  in  1  clock.
REQ-008 rst_ni  in  1  synchronous active-low reset.
REQ-009 wb_valid_i  in  N  per-entry valid from the wait buffer.
REQ-010 wb_entries_i  in  N x entry_t  entry contents: pc, act_mask, tag, dst_reg, operands_ready, operand_tags, operands.
REQ-011 wb_insert_i  in  N  one-hot pulse: entry written this cycle.
REQ-012 eu_valid_i / eu_tag_i  in  1 / TagWidth  result-writeback broadcast.
REQ-013 wb_release_o  out  N  one-hot pulse: free this entry.
REQ-014 credit_give_o  out  1  pulse to the fetcher credit counter.
REQ-015 opc_valid_o  out  1; opc_ready_i  in  1: operand-collector handshake.
REQ-016 opc_pc_o, opc_act_mask_o, opc_tag_o, opc_dst_reg_o, opc_operands_o  out  entry widths  registered payload.

Function
REQ-017 Per entry i, operand k: woken_q[i][k] SHALL be set when eu_valid_i and eu_tag_i equals operand_tags[k] and wb_valid_i[i].
REQ-018 On wb_insert_i[i], woken_q[i][*] SHALL clear, except a bit whose tag matches a same-cycle writeback SHALL set.
REQ-019 An entry SHALL be eligible when valid and, for every k, operands_ready[k] or woken_q[k] holds; a same-cycle writeback SHALL NOT count.
REQ-020 Age SHALL be tracked with an NxN older-than matrix updated on insert; selection SHALL pick the oldest eligible entry.
REQ-021 Ties between entries of equal age SHALL NOT occur: at most one insert per cycle.
REQ-022 The output register SHALL load when the register is empty, or when opc_valid_o and opc_ready_i, and an entry is eligible.
REQ-023 On load, wb_release_o[sel] and credit_give_o SHALL pulse for exactly that cycle, and the payload SHALL appear at opc_*_o the next cycle.
REQ-024 Latency SHALL be one cycle from eligible to opc_valid_o.
REQ-025 While opc_valid_o and not opc_ready_i, all opc_*_o SHALL hold stable and there SHALL be no release.
REQ-026 Back-to-back issue SHALL sustain one instruction per cycle when opc_ready_i stays high.
REQ-027 With no eligible entry and the register draining, opc_valid_o SHALL fall next cycle.
REQ-028 A released entry SHALL NOT be reselected; the wait buffer deasserts valid on the next cycle.
REQ-029 Inputs wb_insert_i[i] and wb_valid_i[i] both high SHALL be an assertion failure.

Reset
REQ-030 While rst_ni is low at a clock edge, the block SHALL clear opc_valid_o, woken_q, the age matrix and the payload to 0.
REQ-031 While in reset, wb_release_o and credit_give_o SHALL be 0.
REQ-032 Reset mid-stall SHALL drop the held instruction without a release pulse.

Structure
REQ-033 entry_t (the wait-buffer entry struct), tag_t and reg_idx_t SHALL live in the shared dispatcher package, also used by wait_buffer.
REQ-034 Oldest-eligible selection SHALL be the sub-module age_matrix_arbiter (N-wide, with insert and request vectors, one-hot grant).

Verification
REQ-035 Entry 0 has ready=11 at reset exit, opc_ready_i=1 -> release[0] pulses at cycle 1; opc_valid_o=1 with pc of entry 0 at cycle 2.
REQ-036 Entries 0 and 1 have ready=01 and operand tag 3 -> eu_tag_i=3 pulse -> both eligible next cycle; the older issues first, the other one cycle later.
REQ-037 opc_ready_i=0 for 5 cycles with 3 eligible entries -> payload stable, no release; then 3 consecutive issues.
REQ-038 Insert entry 2 with tag 5 in the same cycle as an eu_tag_i=5 writeback -> woken set, dispatch with no further writeback.
REQ-039 Writeback eu_tag_i=4 arrives for an operand tag of 4 on a non-valid entry -> no woken bit, no issue.
REQ-040 rst_ni low during a stall -> opc_valid_o=0 next cycle, credit_give_o never pulses.
